// File: rtl/miriscv_decoder_pkg.sv
// MIRISCV decoder shared definitions: opcodes, ALU codes,
// operand/LSU/write-back select encodings and the control bundle.
package miriscv_decoder_pkg;

  localparam int ALU_OP_WIDTH = 6;

  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OP_IMM   = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcodeE;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_LTS  = 6'b000000,
    ALU_LTU  = 6'b000001,
    ALU_SLTS = 6'b000010,
    ALU_SLTU = 6'b000011,
    ALU_GES  = 6'b001010,
    ALU_GEU  = 6'b001011,
    ALU_EQ   = 6'b001100,
    ALU_NE   = 6'b001101,
    ALU_AND  = 6'b010101,
    ALU_ADD  = 6'b011000,
    ALU_SUB  = 6'b011001,
    ALU_SRA  = 6'b100100,
    ALU_SRL  = 6'b100101,
    ALU_SLL  = 6'b100111,
    ALU_OR   = 6'b101110,
    ALU_XOR  = 6'b101111
  } aluOpE;

  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic WB_EX_RESULT = 1'b0;
  localparam logic WB_LSU_DATA  = 1'b1;

  typedef struct packed {
    logic [1:0] opASel;
    logic [2:0] opBSel;
    aluOpE      aluOp;
    logic       memReq;
    logic       memWe;
    logic [2:0] memSize;
    logic       gprWe;
    logic       wbSel;
    logic       branch;
    logic       jal;
    logic       jalr;
  } ctrlT;

  localparam ctrlT CTRL_DEFAULT = '{
    opASel:  OP_A_RS1,
    opBSel:  OP_B_RS2,
    aluOp:   ALU_ADD,
    memReq:  1'b0,
    memWe:   1'b0,
    memSize: LDST_W,
    gprWe:   1'b0,
    wbSel:   WB_EX_RESULT,
    branch:  1'b0,
    jal:     1'b0,
    jalr:    1'b0
  };

endpackage

// File: rtl/miriscv_alu_op_decode.sv
// funct3/funct7 to ALU opcode mapping for OP, OP_IMM and BRANCH.
// Every other opcode maps to ADD and is reported legal here.
module miriscv_alu_op_decode
  import miriscv_decoder_pkg::*;
(
  input  opcodeE     opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output aluOpE      aluOp,
  output logic       legal
);

  always_comb begin
    aluOp = ALU_ADD;
    legal = 1'b1;
    unique case (1'b1)
      opcode == OPC_OP_IMM: begin
        case (funct3)
          3'd0: aluOp = ALU_ADD;
          3'd1: begin
            aluOp = ALU_SLL;
            legal = funct7 == 7'h00;
          end
          3'd2: aluOp = ALU_SLTS;
          3'd3: aluOp = ALU_SLTU;
          3'd4: aluOp = ALU_XOR;
          3'd5: begin
            aluOp = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'd6: aluOp = ALU_OR;
          default: aluOp = ALU_AND;
        endcase
      end
      opcode == OPC_OP: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: aluOp = ALU_ADD;
            3'd1: aluOp = ALU_SLL;
            3'd2: aluOp = ALU_SLTS;
            3'd3: aluOp = ALU_SLTU;
            3'd4: aluOp = ALU_XOR;
            3'd5: aluOp = ALU_SRL;
            3'd6: aluOp = ALU_OR;
            default: aluOp = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          aluOp = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          aluOp = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      opcode == OPC_BRANCH: begin
        case (funct3)
          3'd0: aluOp = ALU_EQ;
          3'd1: aluOp = ALU_NE;
          3'd4: aluOp = ALU_LTS;
          3'd5: aluOp = ALU_GES;
          3'd6: aluOp = ALU_LTU;
          3'd7: aluOp = ALU_GEU;
          default: legal = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/miriscv_decoder.sv
// MIRISCV RV32I main decoder: combinational control decode plus a
// saturating count of cycles spent on illegal instructions.
module miriscv_decoder
  import miriscv_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic [31:0]             fetched_instr_i,
  output logic [1:0]              ex_op_a_sel_o,
  output logic [2:0]              ex_op_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic                    gpr_we_a_o,
  output logic                    wb_src_sel_o,
  output logic                    illegal_instr_o,
  output logic                    branch_o,
  output logic                    jal_o,
  output logic                    jalr_o,
  output logic [CNT_W-1:0]        illegal_cnt_o
);

  opcodeE     opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  aluOpE      fnAluOp;
  logic       fnLegal;
  logic       opLegal;
  logic       illegal;
  ctrlT       raw;
  ctrlT       ctrl;
  logic       unusedBits;

  assign opcode     = opcodeE'(fetched_instr_i[6:2]);
  assign funct3     = fetched_instr_i[14:12];
  assign funct7     = fetched_instr_i[31:25];
  assign unusedBits = ^{fetched_instr_i[24:15], fetched_instr_i[11:7]};

  miriscv_alu_op_decode uAluOpDec (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .aluOp  (fnAluOp),
    .legal  (fnLegal)
  );

  always_comb begin
    raw       = CTRL_DEFAULT;
    raw.aluOp = fnAluOp;
    opLegal   = 1'b1;
    unique case (1'b1)
      opcode == OPC_LOAD: begin
        raw.opBSel  = OP_B_IMM_I;
        raw.memReq  = 1'b1;
        raw.memSize = funct3;
        raw.gprWe   = 1'b1;
        raw.wbSel   = WB_LSU_DATA;
        opLegal     = funct3 inside {LDST_B, LDST_H, LDST_W,
                                     LDST_BU, LDST_HU};
      end
      opcode == OPC_STORE: begin
        raw.opBSel  = OP_B_IMM_S;
        raw.memReq  = 1'b1;
        raw.memWe   = 1'b1;
        raw.memSize = funct3;
        opLegal     = funct3 inside {LDST_B, LDST_H, LDST_W};
      end
      opcode == OPC_OP_IMM: begin
        raw.opBSel = OP_B_IMM_I;
        raw.gprWe  = 1'b1;
      end
      opcode == OPC_OP: begin
        raw.gprWe = 1'b1;
      end
      opcode == OPC_LUI: begin
        raw.opASel = OP_A_ZERO;
        raw.opBSel = OP_B_IMM_U;
        raw.gprWe  = 1'b1;
      end
      opcode == OPC_AUIPC: begin
        raw.opASel = OP_A_CURR_PC;
        raw.opBSel = OP_B_IMM_U;
        raw.gprWe  = 1'b1;
      end
      opcode == OPC_JAL: begin
        raw.opASel = OP_A_CURR_PC;
        raw.opBSel = OP_B_INCR;
        raw.gprWe  = 1'b1;
        raw.jal    = 1'b1;
      end
      opcode == OPC_JALR: begin
        raw.opASel = OP_A_CURR_PC;
        raw.opBSel = OP_B_INCR;
        raw.gprWe  = 1'b1;
        raw.jalr   = 1'b1;
        opLegal    = funct3 == 3'd0;
      end
      opcode == OPC_BRANCH: begin
        raw.branch = 1'b1;
      end
      opcode == OPC_MISC_MEM,
      opcode == OPC_SYSTEM: ;
      default: opLegal = 1'b0;
    endcase
  end

  assign illegal = (fetched_instr_i[1:0] != 2'b11)
                 || !opLegal || !fnLegal;

  // Illegal words collapse to the all-default bundle so no side effect leaks.
  assign ctrl = illegal ? CTRL_DEFAULT : raw;

  assign ex_op_a_sel_o   = ctrl.opASel;
  assign ex_op_b_sel_o   = ctrl.opBSel;
  assign alu_op_o        = ctrl.aluOp;
  assign mem_req_o       = ctrl.memReq;
  assign mem_we_o        = ctrl.memWe;
  assign mem_size_o      = ctrl.memSize;
  assign gpr_we_a_o      = ctrl.gprWe;
  assign wb_src_sel_o    = ctrl.wbSel;
  assign branch_o        = ctrl.branch;
  assign jal_o           = ctrl.jal;
  assign jalr_o          = ctrl.jalr;
  assign illegal_instr_o = illegal;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      illegal_cnt_o <= '0;
    end else if (illegal && illegal_cnt_o != '1) begin
      illegal_cnt_o <= illegal_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_miriscv_decoder.sv
// Scoreboard bench for miriscv_decoder: directed and random words
// checked against an independent RV32I decode model.
module tb_miriscv_decoder;

  typedef struct packed {
    logic [1:0] a;
    logic [2:0] b;
    logic [5:0] alu;
    logic       req;
    logic       we;
    logic [2:0] size;
    logic       gwe;
    logic       wb;
    logic       ill;
    logic       br;
    logic       jal;
    logic       jalr;
  } decT;

  localparam logic [5:0] A_ADD = 6'b011000, A_SUB = 6'b011001;
  localparam logic [5:0] A_SRA = 6'b100100, A_SRL = 6'b100101;

  // index = funct3
  localparam logic [5:0] OP_TAB [8] = '{
    6'b011000, 6'b100111, 6'b000010, 6'b000011,
    6'b101111, 6'b100101, 6'b101110, 6'b010101};
  localparam logic [5:0] BR_TAB [8] = '{
    6'b001100, 6'b001101, 6'b011000, 6'b011000,
    6'b000000, 6'b001010, 6'b000001, 6'b001011};

  localparam decT DEF = '{a: 2'd0, b: 3'd0, alu: A_ADD, req: 1'b0,
    we: 1'b0, size: 3'd2, gwe: 1'b0, wb: 1'b0, ill: 1'b0,
    br: 1'b0, jal: 1'b0, jalr: 1'b0};

  logic        clk = 1'b0;
  logic        arstn;
  logic [31:0] instr;
  logic [1:0]  aSel;
  logic [2:0]  bSel;
  logic [5:0]  aluOp;
  logic        memReq, memWe, gprWe, wbSel, illegalO;
  logic        branch, jal, jalr;
  logic [2:0]  memSize;
  logic [3:0]  cnt;

  int   errors = 0;
  int   checks = 0;
  decT  sb[$];
  logic [3:0] refCnt = '0;

  miriscv_decoder #(.CNT_W(4)) dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .fetched_instr_i (instr),
    .ex_op_a_sel_o   (aSel),
    .ex_op_b_sel_o   (bSel),
    .alu_op_o        (aluOp),
    .mem_req_o       (memReq),
    .mem_we_o        (memWe),
    .mem_size_o      (memSize),
    .gpr_we_a_o      (gprWe),
    .wb_src_sel_o    (wbSel),
    .illegal_instr_o (illegalO),
    .branch_o        (branch),
    .jal_o           (jal),
    .jalr_o          (jalr),
    .illegal_cnt_o   (cnt)
  );

  always #5 clk = ~clk;

  function automatic decT model(input logic [31:0] w);
    decT d = DEF;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit ok = 1;
    if (w[1:0] != 2'b11) ok = 0;
    else case (w[6:2])
      5'b00000: begin
        d.b = 1; d.req = 1; d.size = f3; d.gwe = 1; d.wb = 1;
        ok = (f3 != 3 && f3 != 6 && f3 != 7);
      end
      5'b01000: begin
        d.b = 3; d.req = 1; d.we = 1; d.size = f3;
        ok = (f3 <= 2);
      end
      5'b00100: begin
        d.b = 1; d.gwe = 1;
        d.alu = OP_TAB[f3];
        if (f3 == 5 && f7 == 7'h20) d.alu = A_SRA;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      5'b01100: begin
        d.gwe = 1;
        if (f7 == 0) d.alu = OP_TAB[f3];
        else d.alu = (f3 == 0) ? A_SUB : A_SRA;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end
      5'b01101: begin d.a = 2; d.b = 2; d.gwe = 1; end
      5'b00101: begin d.a = 1; d.b = 2; d.gwe = 1; end
      5'b11011: begin d.a = 1; d.b = 4; d.gwe = 1; d.jal = 1; end
      5'b11001: begin
        d.a = 1; d.b = 4; d.gwe = 1; d.jalr = 1;
        ok = (f3 == 0);
      end
      5'b11000: begin
        d.br = 1; d.alu = BR_TAB[f3];
        ok = (f3 != 2 && f3 != 3);
      end
      5'b00011, 5'b11100: ;
      default: ok = 0;
    endcase
    if (!ok) begin
      d = DEF;
      d.ill = 1;
    end
    return d;
  endfunction

  task automatic issue(input logic [31:0] w);
    @(posedge clk); #1;
    instr = w;
    sb.push_back(model(w));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    instr = 32'h0000_0013;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkCnt(input string name, input logic [3:0] exp);
    checks++;
    if (cnt !== exp) begin
      errors++;
      $display("FAIL %s: cnt=%0d expected %0d", name, cnt, exp);
    end
  endtask

  // Monitor: output is valid on every cycle that has a scoreboard entry.
  initial begin
    decT e, act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = '{a: aSel, b: bSel, alu: aluOp, req: memReq, we: memWe,
          size: memSize, gwe: gprWe, wb: wbSel, ill: illegalO,
          br: branch, jal: jal, jalr: jalr};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL decode instr=%h got=%h expected=%h",
                   instr, act, e);
        end
        checks++;
        if (cnt !== refCnt) begin
          errors++;
          $display("FAIL cnt instr=%h got=%0d expected=%0d",
                   instr, cnt, refCnt);
        end
        if (e.ill && refCnt != 4'hF) refCnt = refCnt + 1'b1;
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] directed [11] = '{
      32'h0000_0013, 32'h4020_8033, 32'h0220_8033, 32'h0000_2003,
      32'h0000_3003, 32'h0000_2023, 32'h0000_006F, 32'h0000_1067,
      32'h0000_6063, 32'h0000_2063, 32'h0000_0037};
    instr = 32'h0000_0013;
    arstn = 1'b1;
    #2 arstn = 1'b0;
    #1 checkCnt("reset", 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;

    issue(32'h0000_0000);
    issue(32'hFFFF_FFFF);
    issue(32'h0220_8033);
    idle();
    drain();
    checkCnt("three_illegal", 4'd3);

    foreach (directed[i]) issue(directed[i]);
    for (int opc = 0; opc < 32; opc++) begin
      for (int k = 0; k < 100; k++) begin
        int r;
        w = $urandom;
        w[6:2] = opc[4:0];
        w[1:0] = 2'b11;
        r = $urandom_range(0, 3);
        if (r == 0) w[31:25] = 7'h00;
        if (r == 1) w[31:25] = 7'h20;
        issue(w);
      end
    end
    for (int k = 0; k < 200; k++) begin
      w = $urandom;
      w[1:0] = 2'($urandom_range(0, 2));
      issue(w);
    end
    idle();
    drain();
    checkCnt("saturate", 4'hF);

    @(posedge clk); #1;
    instr = 32'h0000_0000;
    @(negedge clk);
    arstn = 1'b0;
    #1 checkCnt("async_clear", 4'd0);
    checks++;
    if (illegalO !== 1'b1) begin
      errors++;
      $display("FAIL reset_decode: illegal=%b expected 1", illegalO);
    end
    @(posedge clk); #1;
    checkCnt("held_reset", 4'd0);
    instr = 32'h0000_0013;
    refCnt = '0;
    @(negedge clk);
    arstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkCnt("legal_idle", 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
